// File: rtl/rect_sched_pkg.sv
// Shared constants and types for the rectifier-sharing scheduler.
// The tag travels alongside each sample through the fixed-latency rectifier.
package rect_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 9;
    localparam int CH_W   = $clog2(NUM_CH);

    // -256 has no positive 9-bit counterpart, so it is nudged to -255 before rectification
    localparam logic [DATA_W-1:0] SAT_IN  = 9'h100;
    localparam logic [DATA_W-1:0] SAT_OUT = 9'h101;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
    } tag_t;

endpackage

// File: rtl/rect_share_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner only when the grant is accepted.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              accept,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              any
);

    logic [CH_W-1:0] ptr_reg;
    logic [CH_W-1:0] ptr_next;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] cand;

    // Scan offsets from the far end so the nearest requester is written last
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_reg} + (CH_W + 1)'(i);
            if (sum >= (CH_W + 1)'(NUM_CH)) begin
                sum = sum - (CH_W + 1)'(NUM_CH);
            end
            cand = sum[CH_W-1:0];
            if (req[cand]) begin
                grant_idx = cand;
                any       = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (any) begin
            grant = NUM_CH'(1) << grant_idx;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/rect_share_sched.sv
// Time-shares one fixed-latency rectifier between several channels, tagging
// each sample with its channel and only issuing when the output FIFO can absorb it.
module rect_share_sched #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 9,
    parameter int RECT_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          in_ready,
    output logic [DATA_W-1:0]          rect_data,
    input  logic [DATA_W-1:0]          rect_result,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    input  logic                       out_ready,
    output logic                       busy
);

    import rect_sched_pkg::*;

    localparam int CH_W   = $clog2(NUM_CH);
    // Stage 0 sits beside rect_data; stage RECT_LAT lines up with rect_result
    localparam int STAGES = RECT_LAT + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + STAGES + 1) + 1;

    logic [DATA_W-1:0] sample [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign sample[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              req_any;
    logic              can_issue;
    logic              transfer;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .accept    (transfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (req_any)
    );

    tag_t              tag_reg [STAGES];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    fifo_count_reg;
    logic [CNT_W-1:0]  inflight_count;
    logic              push;
    logic              pop;
    logic              fifo_full;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [CH_W-1:0]   fifo_ch   [FIFO_DEPTH];

    always_comb begin
        inflight_count = '0;
        for (int s = 0; s < STAGES; s++) begin
            inflight_count = inflight_count + CNT_W'(tag_reg[s].valid);
        end
    end

    assign push      = tag_reg[STAGES-1].valid;
    assign out_valid = (fifo_count_reg != '0);
    assign pop       = out_valid & out_ready;
    assign fifo_full = (fifo_count_reg == (PTR_W + 1)'(FIFO_DEPTH));

    // Every in-flight sample already owns a FIFO slot, so nothing can be dropped
    assign can_issue = (CNT_W'(fifo_count_reg) - CNT_W'(pop) + inflight_count + CNT_W'(1))
                       <= CNT_W'(FIFO_DEPTH);
    assign transfer  = req_any & can_issue & ~rst;
    assign in_ready  = grant & {NUM_CH{can_issue & ~rst}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rect_data <= '0;
        end else if (transfer) begin
            rect_data <= (sample[grant_idx] == SAT_IN) ? SAT_OUT : sample[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                tag_reg[s] <= '0;
            end
        end else begin
            tag_reg[0].valid <= transfer;
            tag_reg[0].ch    <= transfer ? grant_idx : '0;
            for (int s = 1; s < STAGES; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= rect_result;
            fifo_ch[wr_ptr_reg]   <= tag_reg[STAGES-1].ch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_reg + PTR_W'(push);
            rd_ptr_reg     <= rd_ptr_reg + PTR_W'(pop);
            fifo_count_reg <= fifo_count_reg + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

    assign out_data = out_valid ? fifo_data[rd_ptr_reg] : '0;
    assign out_ch   = out_valid ? fifo_ch[rd_ptr_reg]   : '0;
    assign busy     = (inflight_count != '0) | (fifo_count_reg != '0);

    no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule
